// File: rtl/usb_buf_pkg.sv
// Shared definitions for the USB endpoint data buffer: capacity, access-size codes
// and the size-code decode used by both the RTL and its users.
package usb_buf_pkg;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned OCC_W = 7;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } size_e;

    // Code 11 is treated as a full word.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] data_size);
        case (size_e'(data_size))
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/data_buffer_if.sv
// AHB-side word port, USB-side byte port and status signals of the data buffer.
interface data_buffer_if;

    logic        store_tx_data;
    logic [31:0] tx_data;
    logic [1:0]  data_size;
    logic        get_rx_data;
    logic [31:0] rx_data;
    logic        store_rx_packet_data;
    logic [7:0]  rx_packet_data;
    logic        get_tx_packet_data;
    logic [7:0]  tx_packet_data;
    logic        clear;
    logic [6:0]  buffer_occupancy;
    logic        overrun;
    logic        underrun;

    modport slave (
        input  store_tx_data, tx_data, data_size, get_rx_data,
        input  store_rx_packet_data, rx_packet_data, get_tx_packet_data, clear,
        output rx_data, tx_packet_data, buffer_occupancy, overrun, underrun
    );

    modport master (
        output store_tx_data, tx_data, data_size, get_rx_data,
        output store_rx_packet_data, rx_packet_data, get_tx_packet_data, clear,
        input  rx_data, tx_packet_data, buffer_occupancy, overrun, underrun
    );

endinterface

// File: rtl/buffer_ram.sv
// Byte-wide register file with four write lanes and four read lanes; lane k
// addresses base+k, wrapping naturally at DEPTH.
module buffer_ram #(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (i_we[k]) begin
                r_mem[i_waddr + AW'(k)] <= i_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            o_rdata[8*k +: 8] = r_mem[i_raddr + AW'(k)];
        end
    end

endmodule

// File: rtl/data_buffer.sv
// Circular byte FIFO between the AHB-Lite slave (1/2/4-byte accesses, little-endian)
// and the USB packet encoder/decoder (single bytes). n_rst is active-high.
module data_buffer
    import usb_buf_pkg::*;
#(
    parameter int unsigned DEPTH = usb_buf_pkg::DEPTH
) (
    input  logic    clk,
    input  logic    n_rst,
    data_buffer_if.slave bus
);

    localparam int unsigned       AW  = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] CAP = OCC_W'(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic [31:0]      r_rx_data;
    logic             r_overrun;
    logic             r_underrun;

    logic [2:0]       w_size_n;
    logic [OCC_W-1:0] w_free;
    logic [3:0]       w_we;
    logic [3:0]       w_we_gated;
    logic [31:0]      w_wdata;
    logic [31:0]      w_rdata;
    logic [31:0]      w_rx_next;
    logic [2:0]       w_push_n;
    logic [2:0]       w_pop_n;
    logic             w_ovf;
    logic             w_unf;
    logic             w_rx_load;

    assign w_size_n   = size_to_bytes(bus.data_size);
    assign w_free     = CAP - r_occ;
    assign w_we_gated = (n_rst || bus.clear) ? 4'b0000 : w_we;

    // Word push beats byte push; a losing byte push counts as dropped.
    always_comb begin
        w_we     = '0;
        w_wdata  = '0;
        w_push_n = '0;
        w_ovf    = 1'b0;
        if (bus.store_tx_data) begin
            w_ovf = bus.store_rx_packet_data;
            if (w_free >= {4'd0, w_size_n}) begin
                w_push_n = w_size_n;
                w_wdata  = bus.tx_data;
                w_we     = 4'((5'd1 << w_size_n) - 5'd1);
            end else begin
                w_ovf = 1'b1;
            end
        end else if (bus.store_rx_packet_data) begin
            if (r_occ < CAP) begin
                w_push_n = 3'd1;
                w_wdata  = {24'd0, bus.rx_packet_data};
                w_we     = 4'b0001;
            end else begin
                w_ovf = 1'b1;
            end
        end
    end

    // Pops read pre-edge memory, so same-cycle pushes are never visible to them.
    always_comb begin
        w_pop_n   = '0;
        w_unf     = 1'b0;
        w_rx_load = 1'b0;
        w_rx_next = '0;
        if (bus.get_rx_data) begin
            w_rx_load = 1'b1;
            w_unf     = ({4'd0, w_size_n} > r_occ);
            w_pop_n   = w_unf ? r_occ[2:0] : w_size_n;
            for (int unsigned k = 0; k < 4; k++) begin
                if (3'(k) < w_pop_n) begin
                    w_rx_next[8*k +: 8] = w_rdata[8*k +: 8];
                end
            end
        end else if (bus.get_tx_packet_data) begin
            if (r_occ != '0) begin
                w_pop_n = 3'd1;
            end else begin
                w_unf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_rx_data  <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + AW'(w_push_n);
            r_rd_ptr   <= r_rd_ptr + AW'(w_pop_n);
            r_occ      <= r_occ + OCC_W'(w_push_n) - OCC_W'(w_pop_n);
            r_overrun  <= w_ovf;
            r_underrun <= w_unf;
            if (w_rx_load) begin
                r_rx_data <= w_rx_next;
            end
        end
    end

    buffer_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we_gated),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign bus.rx_data          = r_rx_data;
    assign bus.tx_packet_data   = w_rdata[7:0];
    assign bus.buffer_occupancy = r_occ;
    assign bus.overrun          = r_overrun;
    assign bus.underrun         = r_underrun;

endmodule

// File: tb/tb_data_buffer.sv
// Scoreboard bench for data_buffer: a byte-queue model supplies expected pop data,
// pushed to exp_q when a pop is driven and compared when the DUT presents it.
module tb_data_buffer;

    logic clk = 1'b0;
    logic n_rst;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  model[$];
    logic [31:0] exp_q[$];
    int unsigned tb_rd = 0;

    data_buffer_if bus();

    data_buffer #(.DEPTH(64)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        bus.store_tx_data        = 1'b0;
        bus.get_rx_data          = 1'b0;
        bus.store_rx_packet_data = 1'b0;
        bus.get_tx_packet_data   = 1'b0;
        bus.clear                = 1'b0;
        n_rst                    = 1'b0;
    endtask

    task automatic word_push(input logic [31:0] d, input logic [1:0] sz);
        int n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        bus.store_tx_data = 1'b1;
        bus.tx_data       = d;
        bus.data_size     = sz;
        if (model.size() + n <= 64)
            for (int k = 0; k < n; k++) model.push_back(d[8*k +: 8]);
    endtask

    task automatic byte_push(input logic [7:0] b);
        bus.store_rx_packet_data = 1'b1;
        bus.rx_packet_data       = b;
        if (model.size() < 64) model.push_back(b);
    endtask

    task automatic word_pop(input logic [1:0] sz);
        int n;
        int m;
        logic [31:0] e;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        m = (n < model.size()) ? n : model.size();
        e = '0;
        for (int k = 0; k < m; k++) e[8*k +: 8] = model.pop_front();
        tb_rd += m;
        bus.get_rx_data = 1'b1;
        bus.data_size   = sz;
        exp_q.push_back(e);
    endtask

    task automatic byte_pop();
        bus.get_tx_packet_data = 1'b1;
        if (model.size() > 0) begin
            exp_q.push_back({24'd0, model.pop_front()});
            tb_rd++;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        tick();
        n_rst = 1'b1;
        tick();
        model.delete();
        tb_rd = 0;
        checks++;
        if (bus.buffer_occupancy !== 7'd0) begin
            errors++; $display("FAIL reset_occ: got %0d expected 0", bus.buffer_occupancy);
        end
        checks++;
        if (bus.rx_data !== 32'd0) begin
            errors++; $display("FAIL reset_rx_data: got %h expected 0", bus.rx_data);
        end
        checks++;
        if (bus.overrun !== 1'b0 || bus.underrun !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got ovr=%b und=%b expected 0 0", bus.overrun, bus.underrun);
        end
    endtask

    task automatic test_word_push_byte_pop();
        logic [31:0] e;
        word_push(32'hDDCCBBAA, 2'b10);
        tick();
        checks++;
        if (bus.buffer_occupancy !== 7'd4) begin
            errors++; $display("FAIL push4_occ: got %0d expected 4", bus.buffer_occupancy);
        end
        for (int i = 0; i < 4; i++) begin
            byte_pop();
            e = exp_q.pop_front();
            checks++;
            if (bus.tx_packet_data !== e[7:0]) begin
                errors++; $display("FAIL byte_pop%0d: got %h expected %h", i, bus.tx_packet_data, e[7:0]);
            end
            tick();
        end
        checks++;
        if (bus.buffer_occupancy !== 7'd0 || bus.underrun !== 1'b0) begin
            errors++; $display("FAIL pop4_end: got occ=%0d und=%b expected 0 0", bus.buffer_occupancy, bus.underrun);
        end
    endtask

    task automatic test_full_overrun();
        logic [31:0] e;
        for (int i = 0; i < 16; i++) begin
            word_push($urandom, 2'b10);
            tick();
        end
        checks++;
        if (bus.buffer_occupancy !== 7'd64 || bus.overrun !== 1'b0) begin
            errors++; $display("FAIL full_occ: got occ=%0d ovr=%b expected 64 0", bus.buffer_occupancy, bus.overrun);
        end
        byte_push(8'h5A);
        tick();
        checks++;
        if (bus.overrun !== 1'b1 || bus.buffer_occupancy !== 7'd64) begin
            errors++; $display("FAIL full_byte_push: got ovr=%b occ=%0d expected 1 64", bus.overrun, bus.buffer_occupancy);
        end
        tick();
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_pulse_width: got %b expected 0", bus.overrun);
        end
        word_push(32'h00000077, 2'b00);
        tick();
        checks++;
        if (bus.overrun !== 1'b1 || bus.buffer_occupancy !== 7'd64) begin
            errors++; $display("FAIL full_size0_push: got ovr=%b occ=%0d expected 1 64", bus.overrun, bus.buffer_occupancy);
        end
        for (int i = 0; i < 16; i++) begin
            word_pop(2'b10);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (bus.rx_data !== e) begin
                errors++; $display("FAIL drain_word%0d: got %h expected %h", i, bus.rx_data, e);
            end
        end
        checks++;
        if (bus.buffer_occupancy !== 7'd0 || bus.underrun !== 1'b0) begin
            errors++; $display("FAIL drain_end: got occ=%0d und=%b expected 0 0", bus.buffer_occupancy, bus.underrun);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] e;
        byte_push(8'h11); tick();
        byte_push(8'h22); tick();
        byte_push(8'h33); tick();
        checks++;
        if (bus.buffer_occupancy !== 7'd3) begin
            errors++; $display("FAIL short_fill_occ: got %0d expected 3", bus.buffer_occupancy);
        end
        word_pop(2'b10);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.rx_data !== e || bus.rx_data !== 32'h00332211) begin
            errors++; $display("FAIL short_pop_data: got %h expected 00332211", bus.rx_data);
        end
        checks++;
        if (bus.underrun !== 1'b1 || bus.buffer_occupancy !== 7'd0) begin
            errors++; $display("FAIL short_pop_flags: got und=%b occ=%0d expected 1 0", bus.underrun, bus.buffer_occupancy);
        end
        tick();
        checks++;
        if (bus.underrun !== 1'b0 || bus.rx_data !== 32'h00332211) begin
            errors++; $display("FAIL underrun_hold: got und=%b rx=%h expected 0 00332211", bus.underrun, bus.rx_data);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        int guard = 0;
        while ((tb_rd % 64) != 62 && guard < 200) begin
            byte_push(8'(tb_rd));
            tick();
            byte_pop();
            e = exp_q.pop_front();
            checks++;
            if (bus.tx_packet_data !== e[7:0]) begin
                errors++; $display("FAIL advance_head: got %h expected %h", bus.tx_packet_data, e[7:0]);
            end
            tick();
            guard++;
        end
        word_push(32'h44332211, 2'b10);
        tick();
        checks++;
        if (bus.buffer_occupancy !== 7'd4 || bus.tx_packet_data !== 8'h11) begin
            errors++; $display("FAIL wrap_push: got occ=%0d head=%h expected 4 11", bus.buffer_occupancy, bus.tx_packet_data);
        end
        word_pop(2'b10);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.rx_data !== e || bus.rx_data !== 32'h44332211) begin
            errors++; $display("FAIL wrap_pop: got %h expected 44332211", bus.rx_data);
        end
        checks++;
        if (bus.underrun !== 1'b0 || bus.buffer_occupancy !== 7'd0) begin
            errors++; $display("FAIL wrap_end: got und=%b occ=%0d expected 0 0", bus.underrun, bus.buffer_occupancy);
        end
    endtask

    task automatic test_push_pop_same();
        logic [31:0] e;
        for (int i = 0; i < 10; i++) begin
            byte_push(8'hA0 + 8'(i));
            tick();
        end
        byte_pop();
        word_push(32'h0000BEEF, 2'b01);
        e = exp_q.pop_front();
        checks++;
        if (bus.tx_packet_data !== e[7:0]) begin
            errors++; $display("FAIL same_cycle_head: got %h expected %h", bus.tx_packet_data, e[7:0]);
        end
        tick();
        checks++;
        if (bus.buffer_occupancy !== 7'd11) begin
            errors++; $display("FAIL same_cycle_occ: got %0d expected 11", bus.buffer_occupancy);
        end
        for (int i = 0; i < 3; i++) begin
            word_pop(2'b10);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (bus.rx_data !== e) begin
                errors++; $display("FAIL same_cycle_drain%0d: got %h expected %h", i, bus.rx_data, e);
            end
        end
        checks++;
        if (bus.underrun !== 1'b1 || bus.buffer_occupancy !== 7'd0) begin
            errors++; $display("FAIL same_cycle_end: got und=%b occ=%0d expected 1 0", bus.underrun, bus.buffer_occupancy);
        end
    endtask

    task automatic test_conflicts();
        logic [31:0] e;
        word_push(32'h04030201, 2'b01);
        bus.store_rx_packet_data = 1'b1;
        bus.rx_packet_data       = 8'hEE;
        tick();
        checks++;
        if (bus.overrun !== 1'b1 || bus.buffer_occupancy !== 7'd2) begin
            errors++; $display("FAIL push_conflict: got ovr=%b occ=%0d expected 1 2", bus.overrun, bus.buffer_occupancy);
        end
        word_pop(2'b01);
        bus.get_tx_packet_data = 1'b1;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.rx_data !== e || bus.underrun !== 1'b0 || bus.buffer_occupancy !== 7'd0) begin
            errors++; $display("FAIL pop_conflict: got rx=%h und=%b occ=%0d expected %h 0 0",
                               bus.rx_data, bus.underrun, bus.buffer_occupancy, e);
        end
    endtask

    task automatic test_clear_reset();
        logic [31:0] e;
        for (int i = 0; i < 5; i++) begin
            word_push($urandom, 2'b10);
            tick();
        end
        checks++;
        if (bus.buffer_occupancy !== 7'd20) begin
            errors++; $display("FAIL pre_clear_occ: got %0d expected 20", bus.buffer_occupancy);
        end
        word_pop(2'b10);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.rx_data !== e) begin
            errors++; $display("FAIL pre_clear_pop: got %h expected %h", bus.rx_data, e);
        end
        bus.clear         = 1'b1;
        bus.store_tx_data = 1'b1;
        bus.tx_data       = 32'h12345678;
        bus.data_size     = 2'b10;
        tick();
        model.delete();
        tb_rd = 0;
        checks++;
        if (bus.buffer_occupancy !== 7'd0 || bus.overrun !== 1'b0 || bus.rx_data !== e) begin
            errors++; $display("FAIL clear: got occ=%0d ovr=%b rx=%h expected 0 0 %h",
                               bus.buffer_occupancy, bus.overrun, bus.rx_data, e);
        end
        word_push(32'hCAFEF00D, 2'b10);
        tick();
        n_rst           = 1'b1;
        bus.get_rx_data = 1'b1;
        bus.data_size   = 2'b10;
        tick();
        model.delete();
        checks++;
        if (bus.rx_data !== 32'd0 || bus.buffer_occupancy !== 7'd0 || bus.underrun !== 1'b0) begin
            errors++; $display("FAIL reset_mid_pop: got rx=%h occ=%0d und=%b expected 0 0 0",
                               bus.rx_data, bus.buffer_occupancy, bus.underrun);
        end
    endtask

    initial begin
        n_rst                    = 1'b1;
        bus.store_tx_data        = 1'b0;
        bus.tx_data              = '0;
        bus.data_size            = 2'b00;
        bus.get_rx_data          = 1'b0;
        bus.store_rx_packet_data = 1'b0;
        bus.rx_packet_data       = '0;
        bus.get_tx_packet_data   = 1'b0;
        bus.clear                = 1'b0;

        test_reset();
        test_word_push_byte_pop();
        test_full_overrun();
        test_underrun();
        test_wrap();
        test_push_pop_same();
        test_conflicts();
        test_clear_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
